// File: rtl/rr_sel_pkg.sv
// rtl/rr_sel_pkg.sv - shared types and round-robin pick helper for rr_sel_arbiter4
package rr_sel_pkg;

    localparam int NUM_CH = 4;

    typedef logic [1:0] ch_idx_t;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

    // First requester scanning upward from ptr+1; the 2-bit index wraps 3 -> 0.
    function automatic ch_idx_t rr_pick(input logic [NUM_CH-1:0] req, input ch_idx_t ptr);
        ch_idx_t idx;
        logic    found;
        rr_pick = '0;
        found   = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = ptr + ch_idx_t'(i);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/mux4_1.sv
// rtl/mux4_1.sv - single-bit 4:1 multiplexer
module mux4_1 (
    input  logic       d0,
    input  logic       d1,
    input  logic       d2,
    input  logic       d3,
    input  logic [1:0] sel,
    output logic       y
);

    always_comb begin
        y = d0;
        case (sel)
            2'd0: y = d0;
            2'd1: y = d1;
            2'd2: y = d2;
            2'd3: y = d3;
        endcase
    end

endmodule

// File: rtl/rr_sel_arbiter4.sv
// rtl/rr_sel_arbiter4.sv - 4-source round-robin arbiter feeding a 4:1 select into a one-entry output buffer
// Optional burst lock input enabled by macro ARB_LOCK_EN.
module rr_sel_arbiter4
    import rr_sel_pkg::*;
#(
    parameter int DW = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic [DW-1:0]     din0,
    input  logic [DW-1:0]     din1,
    input  logic [DW-1:0]     din2,
    input  logic [DW-1:0]     din3,
`ifdef ARB_LOCK_EN
    input  logic              lock,
`endif
    output logic [NUM_CH-1:0] gnt,
    output ch_idx_t           sel,
    output logic              out_valid,
    output logic [DW-1:0]     out_data,
    output ch_idx_t           out_ch,
    input  logic              out_ready
);

    buf_state_t    state;
    ch_idx_t       ptr;
    ch_idx_t       winner;
    logic          accept;
    logic [DW-1:0] mux_out;

    for (genvar i = 0; i < DW; i++) begin : g_mux
        mux4_1 u_mux (
            .d0  (din0[i]),
            .d1  (din1[i]),
            .d2  (din2[i]),
            .d3  (din3[i]),
            .sel (sel),
            .y   (mux_out[i])
        );
    end

    always_comb begin
        winner = rr_pick(req, ptr);
`ifdef ARB_LOCK_EN
        // A locked burst keeps the last winner as long as it still requests.
        if (lock && req[ptr]) begin
            winner = ptr;
        end
`else
`endif
        accept = (|req) && ((state == BUF_EMPTY) || out_ready);
        gnt    = '0;
        sel    = '0;
        if (accept && rst_n) begin
            gnt[winner] = 1'b1;
            sel         = winner;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BUF_EMPTY;
            ptr      <= ch_idx_t'(NUM_CH - 1);
            out_data <= '0;
            out_ch   <= '0;
        end else if (accept) begin
            state    <= BUF_FULL;
            out_data <= mux_out;
            out_ch   <= winner;
            ptr      <= winner;
        end else if ((state == BUF_FULL) && out_ready) begin
            state    <= BUF_EMPTY;
        end
    end

    assign out_valid = (state == BUF_FULL);

endmodule
